// File: rtl/pin_host_pkg.sv
// Shared types and constants for the pin-bus host.
package pin_host_pkg;

    localparam int PIN_W   = 8;
    localparam int TMO_W   = 8;
    localparam int SETUP_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_DONE     = 3'd4
    } pin_host_state_t;

    localparam logic [PIN_W-1:0] PIN_UI_RST      = '0;
    localparam logic             PIN_STRB_RST    = 1'b0;
    localparam logic [PIN_W-1:0] RSP_DATA_RST    = '0;
    localparam logic             RSP_TIMEOUT_RST = 1'b0;

endpackage

// File: rtl/pin_sync.sv
// Two-flop synchronizer for the responder's pins (ack + response byte).
module pin_sync #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two back-to-back stages; first stage may go metastable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pin_bus_host.sv
// Initiator driving a user project's dedicated pins: byte out on pin_ui with
// a strobe, wait for ack, capture pin_uo, wait for ack release.
// Build option: PIN_HOST_SYNC_EN inserts a 2-flop synchronizer on pin_ack
// and pin_uo (each ack edge then seen 2 cycles later).
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | ready for a request; ack ignored
// ST_SETUP    | pin_ui driven, strobe low, counting setup cycles
// ST_WAIT_ACK | strobe high, waiting for ack high (timeout-guarded)
// ST_RELEASE  | strobe low, response captured, waiting for ack low
// ST_DONE     | one-cycle response pulse, then back to idle
module pin_bus_host
    import pin_host_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [PIN_W-1:0] req_data,
    output logic             rsp_valid,
    output logic [PIN_W-1:0] rsp_data,
    output logic             rsp_timeout,
    output logic             busy,
    output logic [PIN_W-1:0] pin_ui,
    output logic             pin_strb,
    input  logic [PIN_W-1:0] pin_uo,
    input  logic             pin_ack
);

    // Counters are down-counters loaded with N-1 so that the terminal count
    // (zero) lands on the Nth cycle.
    localparam logic [SETUP_W-1:0] SETUP_LOAD = SETUP_W'(SETUP_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LOAD   = TMO_W'(TIMEOUT_CYCLES - 1);

    pin_host_state_t   state_q,     state_d;
    logic [SETUP_W-1:0] setup_cnt_q, setup_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q,   tmo_cnt_d;
    logic [PIN_W-1:0]   pin_ui_q,    pin_ui_d;
    logic               pin_strb_q,  pin_strb_d;
    logic [PIN_W-1:0]   rsp_data_q,  rsp_data_d;
    logic               rsp_tmo_q,   rsp_tmo_d;

    logic               ack_s;
    logic [PIN_W-1:0]   uo_s;

`ifdef PIN_HOST_SYNC_EN
    logic [PIN_W:0] sync_out;

    pin_sync #(.W(PIN_W + 1)) u_pin_sync (
        .clk (clk),
        .rst (rst),
        .d_i ({pin_ack, pin_uo}),
        .q_o (sync_out)
    );

    assign ack_s = sync_out[PIN_W];
    assign uo_s  = sync_out[PIN_W-1:0];
`else
    assign ack_s = pin_ack;
    assign uo_s  = pin_uo;
`endif

    // State, counters and pin/response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            setup_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            pin_ui_q    <= PIN_UI_RST;
            pin_strb_q  <= PIN_STRB_RST;
            rsp_data_q  <= RSP_DATA_RST;
            rsp_tmo_q   <= RSP_TIMEOUT_RST;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            pin_ui_q    <= pin_ui_d;
            pin_strb_q  <= pin_strb_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tmo_q   <= rsp_tmo_d;
        end
    end

    // Next-state logic for the handshake sequence.
    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        pin_ui_d    = pin_ui_q;
        pin_strb_d  = pin_strb_q;
        rsp_data_d  = rsp_data_q;
        rsp_tmo_d   = rsp_tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    pin_ui_d    = req_data;
                    setup_cnt_d = SETUP_LOAD;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (setup_cnt_q == '0) begin
                    pin_strb_d = 1'b1;
                    tmo_cnt_d  = TMO_LOAD;
                    state_d    = ST_WAIT_ACK;
                end else begin
                    setup_cnt_d = setup_cnt_q - 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_s) begin
                    rsp_data_d = uo_s;
                    rsp_tmo_d  = 1'b0;
                    pin_strb_d = 1'b0;
                    tmo_cnt_d  = TMO_LOAD;
                    state_d    = ST_RELEASE;
                end else if (tmo_cnt_q == '0) begin
                    rsp_data_d = RSP_DATA_RST;
                    rsp_tmo_d  = 1'b1;
                    pin_strb_d = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!ack_s) begin
                    rsp_tmo_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (tmo_cnt_q == '0) begin
                    // A stuck ack discards the byte captured earlier.
                    rsp_data_d = RSP_DATA_RST;
                    rsp_tmo_d  = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid   = (state_q == ST_DONE);
    assign rsp_timeout = rsp_valid & rsp_tmo_q;
    assign rsp_data    = rsp_data_q;
    assign pin_ui      = pin_ui_q;
    assign pin_strb    = pin_strb_q;

endmodule

// File: tb/tb_pin_bus_host.sv
// Directed bench for pin_bus_host (SETUP_CYCLES=2, TIMEOUT_CYCLES=8).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
// Cycle-exact steps assume direct sampling; the final latency check also
// covers the PIN_HOST_SYNC_EN build.
module tb_pin_bus_host;

    localparam int SETUP = 2;
    localparam int TMO   = 8;
`ifdef PIN_HOST_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       man_ack = 1'b0;
    logic [7:0] man_uo = 8'h00;
    logic       auto_rsp = 1'b0;

    logic       req_ready, rsp_valid, rsp_timeout, busy, pin_strb, pin_ack;
    logic [7:0] rsp_data, pin_ui, pin_uo;

    int checks = 0;
    int errors = 0;
    int n;
    logic [7:0] exp_b;

    // Immediate responder: echoes the strobe as ack and returns ~pin_ui.
    assign pin_ack = auto_rsp ? pin_strb : man_ack;
    assign pin_uo  = auto_rsp ? ~pin_ui  : man_uo;

    pin_bus_host #(
        .SETUP_CYCLES   (SETUP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .pin_ui      (pin_ui),
        .pin_strb    (pin_strb),
        .pin_uo      (pin_uo),
        .pin_ack     (pin_ack)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset: outputs valid while rst is still asserted.
        #1 rst = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_pin_ui", pin_ui, 8'h00);
        chk("rst_pin_strb", pin_strb, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_pin_ui", pin_ui, 8'h00);

        // Single transfer 0x5A -> 0xA5.
        req_valid = 1'b1;
        req_data  = 8'h5A;
        step();                                  // T0 accept
        req_valid = 1'b0;
        chk("single_pin_ui", pin_ui, 8'h5A);
        chk("single_busy", busy, 1);
        chk("single_ready_low", req_ready, 0);
        chk("single_strb_t0", pin_strb, 0);
        step();                                  // T0+1
        chk("single_strb_t1", pin_strb, 0);
        step();                                  // T0+2: strobe rises
        chk("single_strb_rise", pin_strb, 1);
        man_ack = 1'b1;
        man_uo  = 8'hA5;
        step();                                  // T0+3: ack captured
        chk("single_strb_fall", pin_strb, 0);
        chk("single_no_rsp_early", rsp_valid, 0);
        step();                                  // T0+4: ack still high
        chk("single_wait_release", rsp_valid, 0);
        man_ack = 1'b0;
        step();                                  // T0+5: ack low seen -> DONE
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_data", rsp_data, 8'hA5);
        chk("single_rsp_timeout", rsp_timeout, 0);
        step();
        chk("single_rsp_pulse_end", rsp_valid, 0);
        chk("single_idle", req_ready, 1);

        // Back-to-back with req_valid held and an immediate responder.
        auto_rsp  = 1'b1;
        req_valid = 1'b1;
        req_data  = 8'h01;
        for (int k = 0; k < 3; k++) begin
            step();                              // accept
            chk("b2b_pin_ui", pin_ui, 32'(k + 1));
            if (k < 2) req_data = 8'(k + 2);
            else       req_valid = 1'b0;
            for (int j = 0; j < 3; j++) begin
                step();
                chk("b2b_ready_low", req_ready, 0);
            end
            step();
            exp_b = ~8'(k + 1);
            chk("b2b_rsp_valid", rsp_valid, 1);
            chk("b2b_rsp_data", rsp_data, exp_b);
            chk("b2b_rsp_timeout", rsp_timeout, 0);
            step();
            chk("b2b_ready_again", req_ready, 1);
            chk("b2b_rsp_pulse_end", rsp_valid, 0);
        end

        // No ack: WAIT_ACK times out after 8 cycles.
        auto_rsp  = 1'b0;
        man_ack   = 1'b0;
        req_valid = 1'b1;
        req_data  = 8'h33;
        step();
        req_valid = 1'b0;
        step();
        step();                                  // strobe up
        chk("tmo_strb_rise", pin_strb, 1);
        for (int j = 0; j < TMO - 1; j++) begin
            step();
            chk("tmo_strb_held", pin_strb, 1);
        end
        step();                                  // 8th WAIT_ACK cycle expires
        chk("tmo_strb_fall", pin_strb, 0);
        chk("tmo_rsp_valid", rsp_valid, 1);
        chk("tmo_rsp_timeout", rsp_timeout, 1);
        chk("tmo_rsp_data", rsp_data, 8'h00);
        step();
        chk("tmo_rsp_pulse_end", rsp_valid, 0);
        chk("tmo_idle", req_ready, 1);

        // Next request accepted; ack then sticks high -> RELEASE timeout.
        req_valid = 1'b1;
        req_data  = 8'h44;
        man_ack   = 1'b1;
        man_uo    = 8'hC3;
        step();
        req_valid = 1'b0;
        chk("stuck_accept_busy", busy, 1);
        chk("stuck_pin_ui", pin_ui, 8'h44);
        step();
        step();
        chk("stuck_strb_rise", pin_strb, 1);
        step();                                  // ack captured
        chk("stuck_strb_fall", pin_strb, 0);
        chk("stuck_capture", rsp_data, 8'hC3);
        for (int j = 0; j < TMO - 1; j++) begin
            step();
            chk("stuck_no_rsp", rsp_valid, 0);
        end
        step();
        chk("stuck_rsp_valid", rsp_valid, 1);
        chk("stuck_rsp_timeout", rsp_timeout, 1);
        chk("stuck_rsp_data", rsp_data, 8'h00);
        man_ack = 1'b0;
        step();
        chk("stuck_idle", req_ready, 1);

        // Reset while in WAIT_ACK.
        req_valid = 1'b1;
        req_data  = 8'h77;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        chk("mid_rst_in_wait", pin_strb, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_strb_async", pin_strb, 0);
        chk("mid_rst_pin_ui", pin_ui, 8'h00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 1);
        step();
        chk("mid_rst_no_rsp", rsp_valid, 0);
        rst = 1'b0;
        step();
        chk("mid_rst_no_rsp_after", rsp_valid, 0);
        chk("mid_rst_idle", req_ready, 1);

        // Ack latency from strobe rise and from ack drop (+2 when synchronized).
        man_uo    = 8'h96;
        req_valid = 1'b1;
        req_data  = 8'h69;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("lat_strb_rise", pin_strb, 1);
        man_ack = 1'b1;
        n = 0;
        while (pin_strb && n < 20) begin
            step();
            n++;
        end
        chk("lat_ack_rise", n, 32'(1 + SYNC_LAT));
        chk("lat_capture", rsp_data, 8'h96);
        man_ack = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("lat_ack_fall", n, 32'(1 + SYNC_LAT));
        chk("lat_rsp_timeout", rsp_timeout, 0);
        step();
        chk("lat_idle", req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
